// File: rtl/dmem_responder.sv
// dmem_responder: fixed-latency word memory responder with byte enables and error reporting
// Ports: CLK/RST clock and sync active-high reset; D_MEM_CSN/WEN/BE/ADDR/DI request (CSN, WEN active-low);
//        D_MEM_DOUT read data, D_MEM_READY one-cycle completion, D_MEM_ERR error with READY, D_MEM_BUSY in flight.
module dmem_responder #(
    parameter int LAT   = 2,
    parameter int DEPTH = 256
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        D_MEM_CSN,
    input  logic        D_MEM_WEN,
    input  logic [3:0]  D_MEM_BE,
    input  logic [11:0] D_MEM_ADDR,
    input  logic [31:0] D_MEM_DI,
    output logic [31:0] D_MEM_DOUT,
    output logic        D_MEM_READY,
    output logic        D_MEM_ERR,
    output logic        D_MEM_BUSY
);
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t      state, next_state;
    logic [3:0]  cnt;
    logic [11:0] addr_q;
    logic        wen_q;
    logic [3:0]  be_q;
    logic [31:0] di_q;
    logic        err_q;
    logic [31:0] mem [DEPTH];
    logic        idle, go_resp, f_wen, f_err;
    logic [11:0] f_addr;
    logic [3:0]  f_be;
    logic [31:0] f_di;
    logic [AW-1:0] f_idx;
    // With LAT=1 the commit happens on the accepting edge itself, before the
    // capture registers hold the request, so the live inputs are used in IDLE.
    always_comb begin
        idle    = state == IDLE;
        f_addr  = idle ? D_MEM_ADDR : addr_q;
        f_wen   = idle ? D_MEM_WEN : wen_q;
        f_be    = idle ? D_MEM_BE : be_q;
        f_di    = idle ? D_MEM_DI : di_q;
        f_idx   = f_addr[AW+1:2];
        f_err   = (f_addr[1:0] != 2'b00) || (32'(f_addr[11:2]) >= DEPTH);
        go_resp = (next_state == RESP) && (state != RESP);
    end
    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= next_state;
    end
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (!D_MEM_CSN) next_state = (LAT == 1) ? RESP : WAIT;
            WAIT:    if (cnt == 4'd1) next_state = RESP;
            default: next_state = IDLE;
        endcase
    end
    always_comb begin
        D_MEM_READY = state == RESP;
        D_MEM_BUSY  = state != IDLE;
        D_MEM_ERR   = D_MEM_READY && err_q;
    end
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt        <= 4'd0;
            err_q      <= 1'b0;
            D_MEM_DOUT <= 32'h0;
        end else begin
            if (idle && !D_MEM_CSN) begin
                cnt    <= 4'(LAT - 1);
                addr_q <= D_MEM_ADDR;
                wen_q  <= D_MEM_WEN;
                be_q   <= D_MEM_BE;
                di_q   <= D_MEM_DI;
            end else if (state == WAIT) begin
                cnt <= cnt - 4'd1;
            end
            if (go_resp) begin
                err_q <= f_err;
                if (f_wen && !f_err) D_MEM_DOUT <= mem[f_idx];
            end
        end
    end
    // Storage has no reset; reset only suppresses a pending commit.
    always_ff @(posedge CLK) begin
        if (!RST && go_resp && !f_wen && !f_err)
            for (int i = 0; i < 4; i++)
                if (f_be[i]) mem[f_idx][8*i +: 8] <= f_di[8*i +: 8];
    end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed checks of dmem_responder at LAT 1..4 (instance k has LAT=k+1)
module tb_dmem_responder;
    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [3:0]       csn = 4'hF;
    logic             wen = 1'b1;
    logic [3:0]       be = 4'h0;
    logic [11:0]      addr = 12'h0;
    logic [31:0]      di = 32'h0;
    logic [3:0][31:0] dout;
    logic [3:0]       ready, err, busy;
    int               checks = 0;
    int               errors = 0;

    always #5 clk = ~clk;

    genvar g;
    generate
        for (g = 0; g < 4; g++) begin : g_dut
            dmem_responder #(.LAT(g + 1), .DEPTH(256)) u_dut (
                .CLK(clk), .RST(rst), .D_MEM_CSN(csn[g]), .D_MEM_WEN(wen),
                .D_MEM_BE(be), .D_MEM_ADDR(addr), .D_MEM_DI(di),
                .D_MEM_DOUT(dout[g]), .D_MEM_READY(ready[g]),
                .D_MEM_ERR(err[g]), .D_MEM_BUSY(busy[g])
            );
        end
    endgenerate

    // Issue one request on instance k and measure cycles from the accepting edge to READY.
    // Inputs are scrambled right after acceptance so any use of live inputs shows up.
    task automatic txn(input int k, input logic w, input logic [3:0] b, input logic [11:0] a,
                       input logic [31:0] d, output int lat, output logic e);
        rst = 1'b0; csn[k] = 1'b0; wen = w; be = b; addr = a; di = d;
        @(negedge clk);
        csn[k] = 1'b1; wen = ~w; be = ~b; addr = 12'hFFC; di = ~d;
        lat = 1;
        while (!ready[k] && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        e = err[k];
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; csn = 4'hF;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if ({ready[k], err[k], busy[k]} !== 3'b000) begin
                errors++;
                $display("FAIL reset_flags inst=%0d ready/err/busy=%b expected 000", k, {ready[k], err[k], busy[k]});
            end
            checks++;
            if (dout[k] !== 32'h0) begin
                errors++;
                $display("FAIL reset_dout inst=%0d got=%h expected=00000000", k, dout[k]);
            end
        end
    endtask

    task automatic test_basic();
        int lat; logic e;
        txn(1, 1'b0, 4'hF, 12'h010, 32'hDEADBEEF, lat, e);
        checks++;
        if (lat !== 2 || e !== 1'b0) begin
            errors++; $display("FAIL basic_wr lat=%0d err=%b expected lat=2 err=0", lat, e);
        end
        txn(1, 1'b1, 4'hF, 12'h010, 32'h0, lat, e);
        checks++;
        if (lat !== 2 || e !== 1'b0) begin
            errors++; $display("FAIL basic_rd lat=%0d err=%b expected lat=2 err=0", lat, e);
        end
        checks++;
        if (dout[1] !== 32'hDEADBEEF) begin
            errors++; $display("FAIL basic_dout got=%h expected=deadbeef", dout[1]);
        end
    endtask

    task automatic test_byte_enable();
        int lat; logic e;
        txn(1, 1'b0, 4'hF, 12'h020, 32'h11223344, lat, e);
        txn(1, 1'b0, 4'b0101, 12'h020, 32'hAABBCCDD, lat, e);
        checks++;
        if (lat !== 2 || e !== 1'b0) begin
            errors++; $display("FAIL be_wr lat=%0d err=%b expected lat=2 err=0", lat, e);
        end
        checks++;
        if (dout[1] !== 32'hDEADBEEF) begin
            errors++; $display("FAIL be_dout_hold got=%h expected=deadbeef", dout[1]);
        end
        txn(1, 1'b1, 4'h0, 12'h020, 32'h0, lat, e);
        checks++;
        if (dout[1] !== 32'h11BB33DD || e !== 1'b0) begin
            errors++; $display("FAIL be_rd got=%h err=%b expected=11bb33dd err=0", dout[1], e);
        end
    endtask

    task automatic test_errors();
        int lat; logic e;
        txn(1, 1'b0, 4'hF, 12'h000, 32'h55555555, lat, e);
        txn(1, 1'b1, 4'hF, 12'h022, 32'h0, lat, e);
        checks++;
        if (lat !== 2 || e !== 1'b1 || dout[1] !== 32'h11BB33DD) begin
            errors++; $display("FAIL err_misaligned_rd lat=%0d err=%b dout=%h expected lat=2 err=1 dout=11bb33dd", lat, e, dout[1]);
        end
        txn(1, 1'b1, 4'hF, 12'h400, 32'h0, lat, e);
        checks++;
        if (lat !== 2 || e !== 1'b1 || dout[1] !== 32'h11BB33DD) begin
            errors++; $display("FAIL err_range_rd lat=%0d err=%b dout=%h expected lat=2 err=1 dout=11bb33dd", lat, e, dout[1]);
        end
        txn(1, 1'b0, 4'hF, 12'h400, 32'hFFFFFFFF, lat, e);
        checks++;
        if (lat !== 2 || e !== 1'b1) begin
            errors++; $display("FAIL err_range_wr lat=%0d err=%b expected lat=2 err=1", lat, e);
        end
        txn(1, 1'b0, 4'hF, 12'h022, 32'h00000000, lat, e);
        checks++;
        if (lat !== 2 || e !== 1'b1) begin
            errors++; $display("FAIL err_misaligned_wr lat=%0d err=%b expected lat=2 err=1", lat, e);
        end
        checks++;
        if (dout[1] !== 32'h11BB33DD) begin
            errors++; $display("FAIL err_dout_hold got=%h expected=11bb33dd", dout[1]);
        end
        txn(1, 1'b1, 4'hF, 12'h000, 32'h0, lat, e);
        checks++;
        if (dout[1] !== 32'h55555555 || e !== 1'b0) begin
            errors++; $display("FAIL err_word0_intact got=%h err=%b expected=55555555 err=0", dout[1], e);
        end
        txn(1, 1'b1, 4'hF, 12'h020, 32'h0, lat, e);
        checks++;
        if (dout[1] !== 32'h11BB33DD || e !== 1'b0) begin
            errors++; $display("FAIL err_word8_intact got=%h err=%b expected=11bb33dd err=0", dout[1], e);
        end
    endtask

    task automatic test_lat1();
        int lat; logic e;
        txn(0, 1'b0, 4'hF, 12'h050, 32'hCAFEF00D, lat, e);
        checks++;
        if (lat !== 1 || e !== 1'b0) begin
            errors++; $display("FAIL lat1_wr lat=%0d err=%b expected lat=1 err=0", lat, e);
        end
        txn(0, 1'b0, 4'h0, 12'h050, 32'h00000000, lat, e);
        checks++;
        if (lat !== 1 || e !== 1'b0) begin
            errors++; $display("FAIL lat1_be0_wr lat=%0d err=%b expected lat=1 err=0", lat, e);
        end
        txn(0, 1'b1, 4'h0, 12'h050, 32'h0, lat, e);
        checks++;
        if (lat !== 1 || dout[0] !== 32'hCAFEF00D) begin
            errors++; $display("FAIL lat1_rd lat=%0d dout=%h expected lat=1 dout=cafef00d", lat, dout[0]);
        end
    endtask

    task automatic test_back_to_back();
        int nr = 0;
        int nb = 0;
        csn[2] = 1'b0; wen = 1'b0; be = 4'hF; addr = 12'h040; di = 32'h00001234;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            checks++;
            if (ready[2] !== (i % 4 == 3)) begin
                errors++; $display("FAIL b2b_ready cycle=%0d got=%b expected=%b", i, ready[2], i % 4 == 3);
            end
            checks++;
            if (busy[2] !== (i % 4 != 0)) begin
                errors++; $display("FAIL b2b_busy cycle=%0d got=%b expected=%b", i, busy[2], i % 4 != 0);
            end
            nr += int'(ready[2]);
            nb += int'(busy[2]);
        end
        csn[2] = 1'b1;
        checks++;
        if (nr != 4 || nb != 12) begin
            errors++; $display("FAIL b2b_totals ready=%0d busy=%0d expected ready=4 busy=12", nr, nb);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset_abort();
        int lat; logic e;
        logic seen = 1'b0;
        txn(3, 1'b0, 4'hF, 12'h030, 32'h0BADF00D, lat, e);
        txn(3, 1'b1, 4'hF, 12'h030, 32'h0, lat, e);
        checks++;
        if (lat !== 4 || dout[3] !== 32'h0BADF00D) begin
            errors++; $display("FAIL abort_setup lat=%0d dout=%h expected lat=4 dout=0badf00d", lat, dout[3]);
        end
        csn[3] = 1'b0; wen = 1'b0; be = 4'hF; addr = 12'h030; di = 32'hFFFFFFFF;
        @(negedge clk);
        csn[3] = 1'b1;
        checks++;
        if (busy[3] !== 1'b1) begin
            errors++; $display("FAIL abort_busy got=%b expected=1", busy[3]);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({ready[3], err[3], busy[3]} !== 3'b000 || dout[3] !== 32'h0) begin
            errors++; $display("FAIL abort_reset_state flags=%b dout=%h expected flags=000 dout=00000000", {ready[3], err[3], busy[3]}, dout[3]);
        end
        repeat (6) begin
            @(negedge clk);
            seen |= ready[3];
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++; $display("FAIL abort_no_ready got=%b expected=0", seen);
        end
        txn(3, 1'b1, 4'hF, 12'h030, 32'h0, lat, e);
        checks++;
        if (lat !== 4 || e !== 1'b0 || dout[3] !== 32'h0BADF00D) begin
            errors++; $display("FAIL abort_readback lat=%0d err=%b dout=%h expected lat=4 err=0 dout=0badf00d", lat, e, dout[3]);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_byte_enable();
        test_errors();
        test_lat1();
        test_back_to_back();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL have parameter LAT, default 2, meaning the number of cycles from request acceptance to response (legal range 1..15).
REQ-002 The block SHALL have parameter DEPTH, default 256, meaning the number of 32-bit words of storage.
REQ-003 The block SHALL have port CLK  input  1  the only clock; all state changes on its rising edge.
REQ-004 The block SHALL have port RST  input  1  reset; synchronous and active-high.
REQ-005 The block SHALL have port D_MEM_CSN  input  1  chip select, active-low; request present when 0.
REQ-006 The block SHALL have port D_MEM_WEN  input  1  write enable, active-low; 0 = write, 1 = read.
REQ-007 The block SHALL have port D_MEM_BE  input  4  byte enables; bit i selects byte lane i (bits 8i+7..8i).
REQ-008 The block SHALL have port D_MEM_ADDR  input  12  byte address.
REQ-009 The block SHALL have port D_MEM_DI  input  32  write data.
REQ-010 The block SHALL have port D_MEM_DOUT  output  32  read data.
REQ-011 The block SHALL have port D_MEM_READY  output  1  one-cycle completion pulse.
REQ-012 The block SHALL have port D_MEM_ERR  output  1  error flag, valid only while D_MEM_READY=1.
REQ-013 The block SHALL have port D_MEM_BUSY  output  1  high while a request is in flight.

Function
REQ-014 The block SHALL implement states IDLE, WAIT and RESP.
REQ-015 In IDLE, at a rising edge with D_MEM_CSN=0, the block SHALL capture ADDR, WEN, BE and DI, load the latency counter with LAT-1, and move to WAIT if LAT>1, or to RESP if LAT=1.
REQ-016 In WAIT, the counter SHALL decrement by one per cycle, and the block SHALL move to RESP on the edge where the counter equals 1.
REQ-017 The block SHALL raise D_MEM_READY for exactly the single RESP cycle, i.e. exactly LAT cycles after the accepting edge, and then return to IDLE unconditionally.
REQ-018 The block SHALL sample D_MEM_CSN only in IDLE; requests presented in WAIT or RESP SHALL be ignored and never queued, so the earliest next acceptance is the edge ending the first IDLE cycle after RESP.
REQ-019 D_MEM_BUSY SHALL be 1 in WAIT and RESP and 0 in IDLE.
REQ-020 Word index SHALL be ADDR[11:2]; a request SHALL be in error if ADDR[1:0]!=0 or the word index >= DEPTH.
REQ-021 A write SHALL commit on the edge entering RESP, updating only the byte lanes with BE[i]=1 using the captured DI.
REQ-022 A write with BE=4'b0000 SHALL change no storage and SHALL still complete with D_MEM_READY and D_MEM_ERR=0.
REQ-023 A read SHALL load D_MEM_DOUT with the full addressed word on the edge entering RESP, ignoring BE.
REQ-024 D_MEM_DOUT SHALL hold its value until the next successful read completes; writes and errors SHALL not change it.
REQ-025 An erroneous request SHALL complete with normal latency, D_MEM_READY=1 and D_MEM_ERR=1, with no storage write and no D_MEM_DOUT update.
REQ-026 D_MEM_ERR SHALL be 0 whenever D_MEM_READY=0.
REQ-027 Captured request fields SHALL be used for the whole transaction; input changes after acceptance SHALL have no effect.

Reset
REQ-028 With RST=1 at a rising edge, the block SHALL go to IDLE and set D_MEM_READY=0, D_MEM_ERR=0, D_MEM_BUSY=0, D_MEM_DOUT=32'h0 and the counter to 0.
REQ-029 RST SHALL take priority over all other inputs.
REQ-030 Reset asserted mid-transaction SHALL abort it with no write committed and no READY pulse.
REQ-031 Storage contents SHALL not be altered by reset.
REQ-032 A request with D_MEM_CSN=0 on the first edge after RST deasserts SHALL be accepted.

Verification
REQ-033 The bench SHALL cover: LAT=2, write ADDR=12'h010, DI=32'hDEADBEEF, BE=4'hF, then read 12'h010 -> READY exactly 2 cycles after each accept, DOUT=32'hDEADBEEF, ERR=0.
REQ-034 The bench SHALL cover: word at 12'h020 = 32'h11223344, write BE=4'b0101, DI=32'hAABBCCDD, then read -> DOUT=32'h11BB33DD.
REQ-035 The bench SHALL cover: read 12'h022 (misaligned) and read 12'h400 with DEPTH=256 (out of range) -> READY with ERR=1 each time, DOUT unchanged, storage unchanged.
REQ-036 The bench SHALL cover: CSN held 0 continuously with LAT=3 -> accepts every 4 cycles (3 latency + 1 IDLE), one READY per accept, BUSY=1 for 3 of every 4 cycles.
REQ-037 The bench SHALL cover: write to 12'h030 with RST pulsed 1 cycle after accept (LAT=4), then read 12'h030 -> no READY for the aborted write, old data returned, outputs at reset values after the RST edge.
REQ-038 The bench SHALL cover: LAT=1, write with BE=4'b0000 -> READY on the next cycle, ERR=0, word unchanged on readback.
